xsnd_sequencer: RTL and testbench

//  Memory-mapped NCH-channel note sequencer and square-wave tone generator for picoVersat.
//  The CPU queues (period, duration) notes per channel; each channel plays its queue autonomously.

---
 rtl/xsnd_sequencer_pkg.sv | 36 +++
 rtl/xsnd_sequencer_fifo.sv | 83 ++++++++
 rtl/xsnd_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_xsnd_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xsnd_sequencer_pkg.sv
// Shared definitions for the xsnd note sequencer: register map, CTRL/STATUS
// bit positions, channel FSM states and the channel-address width helper.
package xsnd_sequencer_pkg;

  // Register offsets within a channel (addr[1:0])
  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_NOTE   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_FLUSH_BIT  = 1;
  localparam int unsigned CTRL_LOOP_BIT   = 2;
  localparam int unsigned CTRL_OVFCLR_BIT = 3;

  // STATUS bit positions; count occupies [ST_COUNT_LSB +: clog2(DEPTH)+1]
  localparam int unsigned ST_PLAYING_BIT = 0;
  localparam int unsigned ST_EMPTY_BIT   = 1;
  localparam int unsigned ST_FULL_BIT    = 2;
  localparam int unsigned ST_OVF_BIT     = 3;
  localparam int unsigned ST_COUNT_LSB   = 4;

  // Per-channel player state
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_LOAD = 2'd1,
    CH_PLAY = 2'd2
  } ch_state_e;

  // Channel field width in the address: at least one bit even for 1-2 channels
  function automatic int unsigned ch_addr_w(input int unsigned nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/xsnd_sequencer_fifo.sv
// Single-clock note FIFO with registered count/full/empty and show-ahead read.
// With SND_SEQ_LOOP_EN defined, a second write port re-queues the popped head
// at the tail in the same cycle as the pop.
module xsnd_sequencer_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
`ifdef SND_SEQ_LOOP_EN
  input  logic                     repush,
  input  logic [WIDTH-1:0]         rewdata,
`endif
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cpu_slot;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok, re_ok;

  // Accept/advance decisions; clear has priority over any push or pop
  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & ~empty_q;
`ifdef SND_SEQ_LOOP_EN
    re_ok    = repush & pop_ok;
`else
    re_ok    = 1'b0;
`endif
    cpu_slot = wr_ptr_q + AW'(re_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok) + AW'(re_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) + CW'(re_ok) - CW'(pop_ok);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage; the re-queued head lands before a same-cycle CPU entry
  always_ff @(posedge clk) begin
`ifdef SND_SEQ_LOOP_EN
    if (re_ok && !clr) mem_q[wr_ptr_q] <= rewdata;
`endif
    if (push_ok && !clr) mem_q[cpu_slot] <= wdata;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/xsnd_sequencer.sv
// NCH-channel memory-mapped note sequencer / square-wave tone generator.
// Each channel owns a note FIFO and a small player FSM; channel waves are
// OR-mixed onto snd. Optional queue replay is enabled by SND_SEQ_LOOP_EN.
module xsnd_sequencer
  import xsnd_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NCH      = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PER_W    = 16,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned TICK_DIV = 50000,
  localparam int unsigned CH_AW   = ch_addr_w(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [CH_AW+1:0]  addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              snd,
  output logic [NCH-1:0]    snd_ch,
  output logic [NCH-1:0]    led_out
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned NOTE_W = PER_W + DUR_W;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [1:0]       reg_sel;
  logic [CH_AW-1:0] ch_sel;
  logic             wr_en;
  logic [DATA_W-1:0] ch_rdata [NCH];
  logic             snd_q;
  logic             unused_data;

  assign reg_sel     = addr[1:0];
  assign ch_sel      = addr[CH_AW+1:2];
  assign wr_en       = sel & we;
  assign unused_data = ^data_in;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic              hit, wr_per, wr_note, wr_ctrl, flush;
    logic [PER_W-1:0]  per_stage_q, per_stage_d;
    logic              en_q, en_d, ovf_q, ovf_d;
    logic              loop_rd;
    logic              fifo_full, fifo_empty, pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [NOTE_W-1:0] head;
    ch_state_e         state_q, state_d;
    logic [PER_W-1:0]  per_q, per_d, half_q, half_d;
    logic [DUR_W-1:0]  dur_q, dur_d, tick_q, tick_d;
    logic [TICK_W-1:0] pre_q, pre_d;
    logic              sq_q, sq_d, led_q, led_d, tick_end, last_clk;
    logic [DATA_W-1:0] rdata;

    assign hit     = wr_en & (ch_sel == CH_AW'(c));
    assign wr_per  = hit & (reg_sel == REG_PERIOD);
    assign wr_note = hit & (reg_sel == REG_NOTE);
    assign wr_ctrl = hit & (reg_sel == REG_CTRL);
    assign flush   = wr_ctrl & data_in[CTRL_FLUSH_BIT];
    // A CTRL write takes effect on the FSM in the same cycle it is accepted
    assign en_d    = wr_ctrl ? data_in[CTRL_EN_BIT] : en_q;

`ifdef SND_SEQ_LOOP_EN
    logic loop_q, loop_d;
    assign loop_d  = wr_ctrl ? data_in[CTRL_LOOP_BIT] : loop_q;
    assign loop_rd = loop_q;

    // Loop-mode flag register
    always_ff @(posedge clk) begin
      if (rst) loop_q <= 1'b0;
      else     loop_q <= loop_d;
    end
`else
    assign loop_rd = 1'b0;
`endif

    // Staged period and sticky overflow next-state
    always_comb begin
      per_stage_d = per_stage_q;
      ovf_d       = ovf_q;
      if (wr_per) per_stage_d = data_in[PER_W-1:0];
      if (wr_ctrl && data_in[CTRL_OVFCLR_BIT]) ovf_d = 1'b0;
      if (wr_note && fifo_full) ovf_d = 1'b1;
    end

    // Channel configuration registers
    always_ff @(posedge clk) begin
      if (rst) begin
        per_stage_q <= '0;
        en_q        <= 1'b0;
        ovf_q       <= 1'b0;
      end else begin
        per_stage_q <= per_stage_d;
        en_q        <= en_d;
        ovf_q       <= ovf_d;
      end
    end

    xsnd_sequencer_fifo #(
      .WIDTH (NOTE_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .push    (wr_note),
      .wdata   ({per_stage_q, data_in[DUR_W-1:0]}),
`ifdef SND_SEQ_LOOP_EN
      .repush  (pop & loop_d),
      .rewdata (head),
`endif
      .pop     (pop),
      .rdata_c (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
    );

    // Player next-state: pop/latch, rest handling, tick and half-period counting
    always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      dur_d    = dur_q;
      pre_d    = pre_q;
      tick_d   = tick_q;
      half_d   = half_q;
      sq_d     = sq_q;
      pop      = 1'b0;
      tick_end = (pre_q == TICK_W'(TICK_DIV - 1));
      last_clk = tick_end && (tick_q == dur_q - DUR_W'(1));
      unique case (state_q)
        CH_IDLE: begin
          sq_d = 1'b0;
          if (en_d && !fifo_empty) begin
            pop     = 1'b1;
            per_d   = head[NOTE_W-1:DUR_W];
            dur_d   = head[DUR_W-1:0];
            state_d = CH_LOAD;
          end
        end
        CH_LOAD: begin
          sq_d = 1'b0;
          if (!en_d || dur_q == '0) begin
            state_d = CH_IDLE;
          end else begin
            state_d = CH_PLAY;
            pre_d   = '0;
            tick_d  = '0;
            half_d  = '0;
            sq_d    = (per_q != '0);
          end
        end
        CH_PLAY: begin
          if (!en_d) begin
            state_d = CH_IDLE;
            sq_d    = 1'b0;
          end else if (last_clk) begin
            sq_d = 1'b0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              per_d   = head[NOTE_W-1:DUR_W];
              dur_d   = head[DUR_W-1:0];
              state_d = CH_LOAD;
            end else begin
              state_d = CH_IDLE;
            end
          end else begin
            if (tick_end) begin
              pre_d  = '0;
              tick_d = tick_q + DUR_W'(1);
            end else begin
              pre_d  = pre_q + TICK_W'(1);
            end
            if (per_q != '0) begin
              if (half_q == per_q - PER_W'(1)) begin
                half_d = '0;
                sq_d   = ~sq_q;
              end else begin
                half_d = half_q + PER_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = CH_IDLE;
          sq_d    = 1'b0;
        end
      endcase
      if (flush) begin
        state_d = CH_IDLE;
        pop     = 1'b0;
        per_d   = per_q;
        dur_d   = dur_q;
        sq_d    = 1'b0;
      end
      led_d = (state_d == CH_PLAY);
    end

    // Player state and counter registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= CH_IDLE;
        per_q   <= '0;
        dur_q   <= '0;
        pre_q   <= '0;
        tick_q  <= '0;
        half_q  <= '0;
        sq_q    <= 1'b0;
        led_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        per_q   <= per_d;
        dur_q   <= dur_d;
        pre_q   <= pre_d;
        tick_q  <= tick_d;
        half_q  <= half_d;
        sq_q    <= sq_d;
        led_q   <= led_d;
      end
    end

    // Per-channel readable registers
    always_comb begin
      rdata = '0;
      case (reg_sel)
        REG_CTRL: begin
          rdata[CTRL_EN_BIT]   = en_q;
          rdata[CTRL_LOOP_BIT] = loop_rd;
        end
        REG_STATUS: begin
          rdata[ST_PLAYING_BIT]            = led_q;
          rdata[ST_EMPTY_BIT]              = fifo_empty;
          rdata[ST_FULL_BIT]               = fifo_full;
          rdata[ST_OVF_BIT]                = ovf_q;
          rdata[ST_COUNT_LSB +: CNT_W]     = fifo_count;
        end
        default: ;
      endcase
    end

    assign ch_rdata[c] = rdata;
    assign snd_ch[c]   = sq_q;
    assign led_out[c]  = led_q;
  end

  // Read mux; channels without an instance read as zero
  always_comb begin
    data_out = '0;
    if (sel && !we) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_sel == CH_AW'(i)) data_out = ch_rdata[i];
      end
    end
  end

  // Speaker mix, one clock behind the channel waves
  always_ff @(posedge clk) begin
    if (rst) snd_q <= 1'b0;
    else     snd_q <= |snd_ch;
  end

  assign snd = snd_q;

endmodule

// File: tb/tb_xsnd_sequencer.sv
// Self-checking bench for xsnd_sequencer (NCH=4, DEPTH=8, TICK_DIV=4).
// Expected waveforms are generated note-by-note from the playback rules.
module tb_xsnd_sequencer;

  localparam int TDIV  = 4;
  localparam int DEPTH = 8;
`ifdef SND_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [3:0]  addr;
  logic [31:0] data_in, data_out;
  logic        snd;
  logic [3:0]  snd_ch, led_out;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic led; logic sq; } obs_t;
  obs_t exp_q[$];
  int   mq_p[$], mq_d[$];

  always #5 clk = ~clk;

  xsnd_sequencer #(
    .DATA_W(32), .NCH(4), .DEPTH(DEPTH), .PER_W(16), .DUR_W(12), .TICK_DIV(TDIV)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .snd(snd), .snd_ch(snd_ch), .led_out(led_out)
  );

  task automatic wr(input int ch, input int r, input int v);
    addr = {2'(ch), 2'(r)}; data_in = 32'(v); sel = 1'b1; we = 1'b1;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] v);
    addr = {2'(ch), 2'(r)}; sel = 1'b1; we = 1'b0;
    #1 v = data_out;
    sel = 1'b0;
  endtask

  function automatic logic [31:0] stat(input int cnt, input bit ovf, input bit play);
    return 32'((cnt << 4) | (int'(ovf) << 3) | (int'(cnt == DEPTH) << 2) |
               (int'(cnt == 0) << 1) | int'(play));
  endfunction

  // LOAD cycle, then D*TDIV playing cycles, or a pass through IDLE for D=0
  function automatic void add_note(input int p, input int d);
    obs_t o;
    o = '0;
    exp_q.push_back(o);
    if (d == 0) exp_q.push_back(o);
    else for (int k = 0; k < d * TDIV; k++) begin
      o.led = 1'b1;
      o.sq  = (p != 0) && (((k / p) % 2) == 0);
      exp_q.push_back(o);
    end
  endfunction

  function automatic void add_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(obs_t'(0));
  endfunction

  task automatic check_trace(input int ch, input string name);
    obs_t o;
    logic prev;
    logic [3:0] el, es;
    logic [8:0] ev, gv;
    int cyc;
    prev = 1'b0; cyc = 0;
    while (exp_q.size() > 0) begin
      o = exp_q.pop_front();
      el = '0; es = '0; el[ch] = o.led; es[ch] = o.sq;
      ev = {el, es, prev};
      gv = {led_out, snd_ch, snd};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL %s cyc=%0d led/snd_ch/snd got=%b exp=%b", name, cyc, gv, ev);
      end
      prev = o.sq; cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({snd, snd_ch, led_out, data_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {snd, snd_ch, led_out, data_out});
    end
    for (int c = 0; c < 4; c++) begin
      rd(c, 3, v);
      checks++;
      if (v !== stat(0, 1'b0, 1'b0)) begin
        failures++; $display("FAIL reset_status ch=%0d got=%h exp=%h", c, v, stat(0, 1'b0, 1'b0));
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_regs();
    logic [31:0] v, e;
    int ch, x;
    for (int i = 0; i < 6; i++) begin
      ch = int'($urandom_range(0, 3)); x = int'($urandom_range(0, 15));
      wr(ch, 2, x);
      rd(ch, 2, v);
      e = 32'((x & 1) | (LOOP ? (x & 4) : 0));
      checks++;
      if (v !== e) begin failures++; $display("FAIL ctrl_read ch=%0d got=%h exp=%h", ch, v, e); end
      rd(ch, 0, v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL period_read ch=%0d got=%h exp=0", ch, v); end
    end
    addr = 4'b0011; data_in = '0; sel = 1'b1; we = 1'b1;
    #1 checks++;
    if (data_out !== 32'd0) begin failures++; $display("FAIL read_during_write got=%h exp=0", data_out); end
    @(negedge clk); sel = 1'b0; we = 1'b0;
    for (int c = 0; c < 4; c++) wr(c, 2, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_note();
    wr(0, 0, 3); wr(0, 1, 2); wr(0, 2, 1);
    add_note(3, 2); add_idle(3);
    check_trace(0, "single_note");
    wr(0, 2, 0);
  endtask

  task automatic test_overflow();
    logic [31:0] v, e;
    bit ovf;
    int p, d;
    ovf = 1'b0; mq_p.delete(); mq_d.delete();
    for (int i = 0; i < 9; i++) begin
      p = int'($urandom_range(0, 4)); d = int'($urandom_range(1, 2));
      wr(1, 0, p); wr(1, 1, d);
      if (mq_p.size() < DEPTH) begin mq_p.push_back(p); mq_d.push_back(d); end
      else ovf = 1'b1;
      rd(1, 3, v);
      e = stat(mq_p.size(), ovf, 1'b0);
      checks++;
      if (v !== e) begin failures++; $display("FAIL fill_status n=%0d got=%h exp=%h", i + 1, v, e); end
    end
    wr(1, 2, 8);
    rd(1, 3, v);
    checks++;
    if (v !== stat(DEPTH, 1'b0, 1'b0)) begin
      failures++; $display("FAIL ovf_clear got=%h exp=%h", v, stat(DEPTH, 1'b0, 1'b0));
    end
    wr(1, 2, 1);
    while (mq_p.size() > 0) add_note(mq_p.pop_front(), mq_d.pop_front());
    add_idle(3);
    check_trace(1, "overflow_playback");
    rd(1, 3, v);
    checks++;
    if (v !== stat(0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL drained_status got=%h exp=%h", v, stat(0, 1'b0, 1'b0));
    end
    wr(1, 2, 0);
  endtask

  task automatic test_flush();
    logic [31:0] v;
    wr(2, 0, 2);
    for (int i = 0; i < 3; i++) wr(2, 1, 3);
    wr(2, 2, 1);
    repeat (6) @(negedge clk);
    checks++;
    if (led_out !== 4'b0100) begin failures++; $display("FAIL flush_pre_play got=%b exp=0100", led_out); end
    wr(2, 2, 3);
    rd(2, 3, v);
    checks++;
    if ({v, snd_ch[2], led_out[2]} !== {stat(0, 1'b0, 1'b0), 2'b00}) begin
      failures++; $display("FAIL flush_now status=%h snd_ch2=%b led2=%b exp status=%h 0 0",
                           v, snd_ch[2], led_out[2], stat(0, 1'b0, 1'b0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({led_out, snd_ch} !== 8'h00) begin
      failures++; $display("FAIL flush_after got=%h exp=00", {led_out, snd_ch});
    end
    wr(2, 2, 0);
    @(negedge clk);
  endtask

  task automatic test_rest_and_zero();
    logic [31:0] v;
    wr(3, 0, 0); wr(3, 1, 3); wr(3, 1, 0); wr(3, 2, 1);
    add_note(0, 3); add_note(0, 0); add_idle(3);
    check_trace(3, "rest_zero");
    rd(3, 3, v);
    checks++;
    if (v !== stat(0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL rest_zero_status got=%h exp=%h", v, stat(0, 1'b0, 1'b0));
    end
    wr(3, 2, 0);
  endtask

  task automatic test_random_notes();
    int ch, n, p, d;
    for (int r = 0; r < 4; r++) begin
      ch = int'($urandom_range(0, 3)); n = int'($urandom_range(2, 5));
      for (int i = 0; i < n; i++) begin
        p = int'($urandom_range(0, 5)); d = int'($urandom_range(0, 3));
        wr(ch, 0, p); wr(ch, 1, d);
        add_note(p, d);
      end
      wr(ch, 2, 1);
      add_idle(2);
      check_trace(ch, "random_notes");
      wr(ch, 2, 0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    for (int c = 0; c < 4; c++) begin wr(c, 0, c + 1); wr(c, 1, 3); end
    for (int c = 0; c < 4; c++) wr(c, 2, 1);
    @(negedge clk);
    checks++;
    if (led_out !== 4'hF) begin failures++; $display("FAIL all_playing got=%b exp=1111", led_out); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({snd, snd_ch, led_out} !== 9'd0) begin
      failures++; $display("FAIL reset_mid_outputs got=%b exp=0", {snd, snd_ch, led_out});
    end
    for (int c = 0; c < 4; c++) begin
      rd(c, 3, v);
      checks++;
      if (v !== stat(0, 1'b0, 1'b0)) begin
        failures++; $display("FAIL reset_mid_status ch=%0d got=%h exp=%h", c, v, stat(0, 1'b0, 1'b0));
      end
      rd(c, 2, v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL reset_mid_ctrl ch=%0d got=%h exp=0", c, v); end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({led_out, snd_ch} !== 8'h00) begin
      failures++; $display("FAIL reset_mid_after got=%h exp=00", {led_out, snd_ch});
    end
  endtask

`ifdef SND_SEQ_LOOP_EN
  task automatic test_loop();
    logic [31:0] v;
    obs_t o;
    logic prev;
    int p1, d1, p2, d2, cnt;
    p1 = int'($urandom_range(1, 3)); d1 = 1;
    p2 = int'($urandom_range(0, 3)); d2 = int'($urandom_range(1, 2));
    wr(0, 0, p1); wr(0, 1, d1); wr(0, 0, p2); wr(0, 1, d2);
    wr(0, 2, 5);
    for (int r = 0; r < 3; r++) begin add_note(p1, d1); add_note(p2, d2); end
    prev = 1'b0;
    while (exp_q.size() > 0) begin
      o = exp_q.pop_front();
      checks++;
      if ({led_out[0], snd_ch[0], snd} !== {o.led, o.sq, prev}) begin
        failures++; $display("FAIL loop_wave got=%b exp=%b", {led_out[0], snd_ch[0], snd}, {o.led, o.sq, prev});
      end
      rd(0, 3, v);
      cnt = int'(v[7:4]);
      checks++;
      if (cnt < 1 || cnt > 2 || v[3] !== 1'b0) begin
        failures++; $display("FAIL loop_status got=%h exp count 1..2 ovf 0", v);
      end
      prev = o.sq;
      @(negedge clk);
    end
    wr(0, 2, 2);
    rd(0, 3, v);
    checks++;
    if (v !== stat(0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL loop_flush got=%h exp=%h", v, stat(0, 1'b0, 1'b0));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_single_note();
    test_overflow();
    test_flush();
    test_rest_and_zero();
    test_random_notes();
`ifdef SND_SEQ_LOOP_EN
    test_loop();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
